// File: rtl/fetch_stage_q.sv
// IF stage: PC register, single-outstanding imem request FSM, prefetch queue and IF/ID register.
// Define FETCH_BYPASS_EN to let responses skip an empty queue and issue back-to-back.
module fetch_stage_q #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemRValid,
  input  logic [ILEN-1:0] ImemRData,
  output logic [ILEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int PTRW = $clog2(FQ_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FQ_DEPTH);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetchStateT;

  fetchStateT state;
  logic            drop;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] tagPc;

  logic [ILEN-1:0] qInstr [FQ_DEPTH];
  logic [XLEN-1:0] qPc    [FQ_DEPTH];
  logic [PTRW-1:0] headPtr;
  logic [PTRW-1:0] tailPtr;
  logic [CNTW-1:0] count;

  logic            qEmpty;
  logic            notFull;
  logic            respValid;
  logic            respKeep;
  logic            decodeAdvance;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            reqWait;
  logic            grant;
  logic [CNTW-1:0] countAfter;
  logic [XLEN-1:0] targetAligned;

  assign targetAligned = {PCTargetE[XLEN-1:2], 2'b00};
  assign qEmpty        = (count == '0);
  assign notFull       = (count < DEPTH_C);
  assign respValid     = (state == S_WAIT) && ImemRValid;
  assign respKeep      = respValid && !drop && !PCSrcE;
  assign decodeAdvance = !FlushD && !PCSrcE && !StallD;
  assign pop           = decodeAdvance && !qEmpty;
  assign push          = respKeep && !bypass;
  assign countAfter    = count + CNTW'(push) - CNTW'(pop);

`ifdef FETCH_BYPASS_EN
  // An empty queue means the response is the oldest word, so it may go straight to IF/ID.
  assign bypass  = respKeep && decodeAdvance && qEmpty;
  assign reqWait = respValid && !PCSrcE && (countAfter < DEPTH_C);
`else
  assign bypass  = 1'b0;
  assign reqWait = 1'b0;
`endif

  assign ImemReq  = !rst && (((state == S_REQ) && notFull) || ((state == S_WAIT) && reqWait));
  assign ImemAddr = pcF;
  assign grant    = ImemReq && ImemGnt;

  // Request FSM and PC; a grant taken alongside a redirect is tracked but its data dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
      pcF   <= RESET_PC;
      tagPc <= '0;
    end else begin
      if (grant) begin
        tagPc <= pcF;
      end
      if (PCSrcE) begin
        pcF <= targetAligned;
        if (state == S_REQ) begin
          if (grant) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end
        end else if (ImemRValid) begin
          state <= S_REQ;
          drop  <= 1'b0;
        end else begin
          drop <= 1'b1;
        end
      end else begin
        unique case (state)
          S_REQ: begin
            if (grant) begin
              state <= S_WAIT;
              drop  <= 1'b0;
              pcF   <= pcF + XLEN'(4);
            end
          end
          S_WAIT: begin
            if (ImemRValid) begin
              drop <= 1'b0;
              if (grant) begin
                state <= S_WAIT;
                pcF   <= pcF + XLEN'(4);
              end else begin
                state <= S_REQ;
              end
            end
          end
        endcase
      end
    end
  end

  // Queue bookkeeping; a redirect empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst || PCSrcE) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tailPtr <= tailPtr + PTRW'(1);
      end
      if (pop) begin
        headPtr <= headPtr + PTRW'(1);
      end
      count <= countAfter;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qInstr[tailPtr] <= ImemRData;
      qPc[tailPtr]    <= tagPc;
    end
  end

  // IF/ID register: flush/redirect beats stall, stall beats refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || PCSrcE) begin
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (bypass) begin
      InstrD   <= ImemRData;
      PCD      <= tagPc;
      PCPlus4D <= tagPc + XLEN'(4);
      ValidD   <= 1'b1;
    end else if (!qEmpty) begin
      InstrD   <= qInstr[headPtr];
      PCD      <= qPc[headPtr];
      PCPlus4D <= qPc[headPtr] + XLEN'(4);
      ValidD   <= 1'b1;
    end else begin
      ValidD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage_q.sv
// Scoreboard bench for fetch_stage_q: an imem model with a grant budget serves fixed words,
// directed scenarios push the instructions decode must see, and a monitor checks them.
module tb_fetch_stage_q;

  logic        clk;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } expT;

  expT sbQ[$];
  int  testsRun;
  int  testsFailed;
  int  grantsLeft;
  int  latency;
  int  cycleNo;

  fetch_stage_q dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemGnt   (ImemGnt),
    .ImemRValid(ImemRValid),
    .ImemRData (ImemRData),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    case (addr)
      32'h000: memRead = 32'h00500093;
      32'h004: memRead = 32'h00A00113;
      32'h008: memRead = 32'h002081B3;
      32'h00C: memRead = 32'h40110233;
      32'h010: memRead = 32'h00418293;
      32'h014: memRead = 32'h0052A023;
      32'h018: memRead = 32'h0002A303;
      32'h01C: memRead = 32'h00000013;
      32'h100: memRead = 32'h00100393;
      32'h104: memRead = 32'h00738433;
      default: memRead = 32'h0BAD0BAD;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic flush, input logic redirect,
                               input logic [31:0] target);
    StallD    = stall;
    FlushD    = flush;
    PCSrcE    = redirect;
    PCTargetE = target;
  endtask

  task automatic expectFetch(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pcPlus4);
    expT e;
    e.instr   = instr;
    e.pc      = pc;
    e.pcPlus4 = pcPlus4;
    sbQ.push_back(e);
  endtask

  // Moves to just after the rising edge that starts cycle c (cycle 0 = first out of reset).
  task automatic goCycle(input int c);
    while (cycleNo < c) begin
      @(posedge clk);
      #1;
      cycleNo++;
    end
  endtask

  task automatic resetDut(input int grants, input int lat);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rstReqA", 32'(ImemReq), 32'h0);
    @(posedge clk);
    #1;
    grantsLeft = grants;
    latency    = lat;
    @(negedge clk);
    checkOutput("rstReqB", 32'(ImemReq), 32'h0);
    checkOutput("rstValidD", 32'(ValidD), 32'h0);
    checkOutput("rstInstrD", InstrD, 32'h0);
    checkOutput("rstPCD", PCD, 32'h0);
    checkOutput("rstPCPlus4D", PCPlus4D, 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cycleNo = 0;
  endtask

  // Instruction memory: one request at a time, fixed latency, grants while budget remains.
  initial begin
    logic        fire;
    logic [31:0] addrQ;
    int          delay;
    bit          busy;
    busy       = 1'b0;
    delay      = 0;
    addrQ      = 32'h0;
    ImemGnt    = 1'b0;
    ImemRValid = 1'b0;
    ImemRData  = 32'h0;
    forever begin
      @(negedge clk);
      fire = !rst && ImemReq && ImemGnt;
      if (fire) begin
        addrQ = ImemAddr;
      end
      @(posedge clk);
      #2;
      ImemRValid = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (fire) begin
          busy = 1'b1;
          delay = latency;
          grantsLeft--;
        end
        if (busy) begin
          delay--;
          if (delay <= 0) begin
            ImemRValid = 1'b1;
            ImemRData  = memRead(addrQ);
            busy       = 1'b0;
          end
        end
      end
      ImemGnt = (grantsLeft > 0);
    end
  end

  // Decode accepts the IF/ID word in any cycle it is valid and neither stalled nor killed.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!rst && ValidD && !StallD && !FlushD && !PCSrcE) begin
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL sbUnexpected: got PCD 0x%08h InstrD 0x%08h, expected no delivery", PCD, InstrD);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sbInstrD", InstrD, e.instr);
          checkOutput("sbPCD", PCD, e.pc);
          checkOutput("sbPCPlus4D", PCPlus4D, e.pcPlus4);
        end
      end
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    grantsLeft  = 0;
    latency     = 1;
    cycleNo     = 0;

    // Reset, then three single-cycle fetches delivered in order.
    resetDut(3, 1);
    expectFetch(32'h00500093, 32'h0, 32'h4);
    expectFetch(32'h00A00113, 32'h4, 32'h8);
    expectFetch(32'h002081B3, 32'h8, 32'hC);
    @(negedge clk);
    checkOutput("t1ReqOut", 32'(ImemReq), 32'h1);
    checkOutput("t1Addr", ImemAddr, 32'h0);
    checkOutput("t1ValidD", 32'(ValidD), 32'h0);
    goCycle(3);
    @(negedge clk);
    checkOutput("t2Pulse", 32'(ValidD), 32'h1);
    goCycle(4);
    @(negedge clk);
    checkOutput("t2Gap", 32'(ValidD), 32'h0);
    goCycle(12);
    @(negedge clk);
    checkOutput("t2Pending", 32'(sbQ.size()), 32'h0);
    checkOutput("t2HoldAddr", ImemAddr, 32'hC);

    // Grant withheld at 0x10: address and request must hold until the grant.
    goCycle(13);
    resetDut(4, 1);
    expectFetch(32'h00500093, 32'h00, 32'h04);
    expectFetch(32'h00A00113, 32'h04, 32'h08);
    expectFetch(32'h002081B3, 32'h08, 32'h0C);
    expectFetch(32'h40110233, 32'h0C, 32'h10);
    expectFetch(32'h00418293, 32'h10, 32'h14);
    for (int c = 8; c <= 10; c++) begin
      goCycle(c);
      @(negedge clk);
      checkOutput("t6ReqHeld", 32'(ImemReq), 32'h1);
      checkOutput("t6AddrHeld", ImemAddr, 32'h10);
    end
    goCycle(11);
    grantsLeft = 1;
    goCycle(12);
    @(negedge clk);
    checkOutput("t6AddrAdv", ImemAddr, 32'h14);
    checkOutput("t6ReqWait", 32'(ImemReq), 32'h0);
    goCycle(20);
    @(negedge clk);
    checkOutput("t6Pending", 32'(sbQ.size()), 32'h0);

    // Twelve-cycle decode stall fills the queue; nothing lost or repeated afterwards.
    goCycle(21);
    resetDut(7, 1);
    expectFetch(32'h00500093, 32'h00, 32'h04);
    expectFetch(32'h00A00113, 32'h04, 32'h08);
    expectFetch(32'h002081B3, 32'h08, 32'h0C);
    expectFetch(32'h40110233, 32'h0C, 32'h10);
    expectFetch(32'h00418293, 32'h10, 32'h14);
    expectFetch(32'h0052A023, 32'h14, 32'h18);
    expectFetch(32'h0002A303, 32'h18, 32'h1C);
    goCycle(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    goCycle(12);
    @(negedge clk);
    checkOutput("t3FullReq", 32'(ImemReq), 32'h0);
    goCycle(16);
    @(negedge clk);
    checkOutput("t3FullReqLate", 32'(ImemReq), 32'h0);
    checkOutput("t3HeldValid", 32'(ValidD), 32'h1);
    checkOutput("t3HeldPCD", PCD, 32'h4);
    checkOutput("t3HeldInstr", InstrD, 32'h00A00113);
    goCycle(17);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    goCycle(28);
    @(negedge clk);
    checkOutput("t3Pending", 32'(sbQ.size()), 32'h0);

    // Redirect to 0x103 while waiting on 0x8 (2-cycle imem) with one entry queued.
    goCycle(29);
    resetDut(5, 2);
    expectFetch(32'h00500093, 32'h000, 32'h004);
    expectFetch(32'h00100393, 32'h100, 32'h104);
    expectFetch(32'h00738433, 32'h104, 32'h108);
    goCycle(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    goCycle(7);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
    goCycle(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4ValidOff", 32'(ValidD), 32'h0);
    checkOutput("t4ReqWait", 32'(ImemReq), 32'h0);
    goCycle(9);
    @(negedge clk);
    checkOutput("t4QueueEmpty", 32'(ValidD), 32'h0);
    checkOutput("t4ReqNew", 32'(ImemReq), 32'h1);
    checkOutput("t4AddrNew", ImemAddr, 32'h100);
    goCycle(24);
    @(negedge clk);
    checkOutput("t4Pending", 32'(sbQ.size()), 32'h0);

    // Flush and stall together with two entries queued: entry 0x4 dies, queue untouched.
    goCycle(25);
    resetDut(4, 1);
    expectFetch(32'h00500093, 32'h00, 32'h04);
    expectFetch(32'h002081B3, 32'h08, 32'h0C);
    expectFetch(32'h40110233, 32'h0C, 32'h10);
    goCycle(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    goCycle(9);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    goCycle(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5ValidOff", 32'(ValidD), 32'h0);
    goCycle(11);
    @(negedge clk);
    checkOutput("t5ValidOn", 32'(ValidD), 32'h1);
    checkOutput("t5OlderPCD", PCD, 32'h8);
    checkOutput("t5OlderPlus4", PCPlus4D, 32'hC);
    goCycle(18);
    @(negedge clk);
    checkOutput("t5Pending", 32'(sbQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
